// File: rtl/rdpiano_bus_pkg.sv
// Shared types and constants for the HD6301-style multiplexed bus master.
package rdpiano_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_IDLE_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    PH_START = 3'd0,
    PH_A     = 3'd1,
    PH_B     = 3'd2,
    PH_C     = 3'd3,
    PH_D     = 3'd4
  } phase_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mcu_bus_driver_if.sv
// Request side and E/AS/RW bus side of the multiplexed bus master.
interface mcu_bus_driver_if;
  import rdpiano_bus_pkg::*;

  logic              REQ_IN;
  logic              REQ_RW_IN;
  logic [ADDR_W-1:0] REQ_ADDR_IN;
  logic [DATA_W-1:0] REQ_WDATA_IN;
  logic              READY_OUT;
  logic              DONE_OUT;
  logic [DATA_W-1:0] RDATA_OUT;
  logic              E_OUT;
  logic              AS_OUT;
  logic              RW_OUT;
  logic [DATA_W-1:0] P4_OUT;
  logic [DATA_W-1:0] P3_OUT;
  logic              P3_IOM;
  logic [DATA_W-1:0] P3_IN;

  modport master (
    input  REQ_IN, REQ_RW_IN, REQ_ADDR_IN, REQ_WDATA_IN, P3_IN,
    output READY_OUT, DONE_OUT, RDATA_OUT, E_OUT, AS_OUT, RW_OUT,
           P4_OUT, P3_OUT, P3_IOM
  );

  modport slave (
    output REQ_IN, REQ_RW_IN, REQ_ADDR_IN, REQ_WDATA_IN, P3_IN,
    input  READY_OUT, DONE_OUT, RDATA_OUT, E_OUT, AS_OUT, RW_OUT,
           P4_OUT, P3_OUT, P3_IOM
  );

endinterface

// File: rtl/mcu_phase_timer.sv
// Counts clocks within a bus phase and phases within a bus cycle.
module mcu_phase_timer #(
  parameter int unsigned PHASE_CLKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic phase_last,
  output logic cycle_last,
  output logic pre_last_c
);

  localparam int unsigned CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    qtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      qtr <= '0;
    end else if (run) begin
      if (phase_last) begin
        cnt <= '0;
        qtr <= qtr + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign phase_last = (32'(cnt) == PHASE_CLKS - 32'd1);
  assign cycle_last = phase_last && (qtr == 2'd3);

  // The clock after this edge will be the last one of its phase.
  assign pre_last_c = (PHASE_CLKS == 32'd1) ||
                      (run && !phase_last && (32'(cnt) + 32'd2 == PHASE_CLKS));

endmodule

// File: rtl/mcu_bus_driver.sv
// HD6301-style bus master: turns single-word requests into E/AS/RW cycles
// on P4 (address high) and P3 (address low / data), with dummy cycles when idle.
module mcu_bus_driver
  import rdpiano_bus_pkg::*;
#(
  parameter int unsigned       PHASE_CLKS = 2,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = DEFAULT_IDLE_ADDR
) (
  input logic              CLK_IN,
  input logic              RESET_IN,
  mcu_bus_driver_if.master bus
);

  localparam bus_req_t IDLE_REQ = '{rw: 1'b1, addr: IDLE_ADDR, wdata: '0};

  phase_t            phase, phase_nx;
  logic              armed;
  bus_req_t          cur, txn_nx;
  logic              cur_valid, txn_valid_nx;
  logic              run_c, phase_last, cycle_last, pre_last_c, accept_c;
  logic              e_nx, as_nx, rw_nx, iom_nx, ready_nx, done_nx;
  logic [DATA_W-1:0] p3_nx, p4_nx;

  assign run_c    = (phase != PH_START);
  assign accept_c = bus.REQ_IN && bus.READY_OUT;

  mcu_phase_timer #(.PHASE_CLKS(PHASE_CLKS)) u_timer (
    .clk        (CLK_IN),
    .rst_n      (RESET_IN),
    .run        (run_c),
    .phase_last (phase_last),
    .cycle_last (cycle_last),
    .pre_last_c (pre_last_c)
  );

  // State register; armed marks the single START clock after reset release.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      phase <= PH_START;
      armed <= 1'b0;
    end else begin
      phase <= phase_nx;
      armed <= 1'b1;
    end
  end

  always_comb begin
    phase_nx = phase;
    case (phase)
      PH_START: if (armed)      phase_nx = PH_A;
      PH_A:     if (phase_last) phase_nx = PH_B;
      PH_B:     if (phase_last) phase_nx = PH_C;
      PH_C:     if (phase_last) phase_nx = PH_D;
      PH_D:     if (phase_last) phase_nx = PH_A;
      default:                  phase_nx = PH_START;
    endcase
  end

  // Transaction carried by the upcoming bus cycle: accepted request or dummy.
  always_comb begin
    txn_nx       = cur;
    txn_valid_nx = cur_valid;
    if (accept_c) begin
      txn_nx       = '{rw: bus.REQ_RW_IN, addr: bus.REQ_ADDR_IN, wdata: bus.REQ_WDATA_IN};
      txn_valid_nx = 1'b1;
    end else if (cycle_last || (phase == PH_START)) begin
      txn_nx       = IDLE_REQ;
      txn_valid_nx = 1'b0;
    end
  end

  // Output values for the clock that follows this edge.
  always_comb begin
    e_nx     = 1'b0;
    as_nx    = 1'b0;
    rw_nx    = 1'b1;
    p4_nx    = '0;
    p3_nx    = '0;
    iom_nx   = 1'b0;
    ready_nx = 1'b0;
    done_nx  = cycle_last && cur_valid;
    case (phase_nx)
      PH_START: ready_nx = 1'b1;
      PH_A, PH_B: begin
        as_nx  = (phase_nx == PH_A);
        rw_nx  = txn_nx.rw;
        p4_nx  = txn_nx.addr[15:8];
        p3_nx  = txn_nx.addr[7:0];
        iom_nx = 1'b1;
      end
      PH_C, PH_D: begin
        e_nx   = 1'b1;
        rw_nx  = txn_nx.rw;
        p4_nx  = txn_nx.addr[15:8];
        p3_nx  = txn_nx.addr[7:0];
        if (txn_valid_nx && !txn_nx.rw) begin
          p3_nx  = txn_nx.wdata;
          iom_nx = 1'b1;
        end
        ready_nx = (phase_nx == PH_D) && pre_last_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      cur           <= '0;
      cur_valid     <= 1'b0;
      bus.E_OUT     <= 1'b0;
      bus.AS_OUT    <= 1'b0;
      bus.RW_OUT    <= 1'b1;
      bus.P4_OUT    <= '0;
      bus.P3_OUT    <= '0;
      bus.P3_IOM    <= 1'b0;
      bus.READY_OUT <= 1'b0;
      bus.DONE_OUT  <= 1'b0;
      bus.RDATA_OUT <= '0;
    end else begin
      cur           <= txn_nx;
      cur_valid     <= txn_valid_nx;
      bus.E_OUT     <= e_nx;
      bus.AS_OUT    <= as_nx;
      bus.RW_OUT    <= rw_nx;
      bus.P4_OUT    <= p4_nx;
      bus.P3_OUT    <= p3_nx;
      bus.P3_IOM    <= iom_nx;
      bus.READY_OUT <= ready_nx;
      bus.DONE_OUT  <= done_nx;
      if (cycle_last && cur_valid && cur.rw) bus.RDATA_OUT <= bus.P3_IN;
    end
  end

endmodule

// File: tb/tb_mcu_bus_driver.sv
// Bench for mcu_bus_driver: two instances (PHASE_CLKS 2 and 1) checked every
// clock against a timeline model, plus directed literal checks.
module tb_mcu_bus_driver;
  import rdpiano_bus_pkg::*;

  typedef struct packed {
    logic       e;
    logic       ast;
    logic       rw;
    logic [7:0] p4;
    logic [7:0] p3;
    logic       iom;
    logic       ready;
    logic       done;
    logic [7:0] rdata;
  } obs_t;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mtxn_t;

  localparam obs_t RST_OBS = '{e: 1'b0, ast: 1'b0, rw: 1'b1, p4: 8'h00, p3: 8'h00,
                               iom: 1'b0, ready: 1'b0, done: 1'b0, rdata: 8'h00};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req       [2];
  logic        req_rw    [2];
  logic [15:0] req_addr  [2];
  logic [7:0]  req_wdata [2];
  logic [7:0]  p3_in     [2];
  obs_t        obs       [2];

  int checks = 0;
  int errors = 0;

  mcu_bus_driver_if bif0 ();
  mcu_bus_driver_if bif1 ();

  mcu_bus_driver #(.PHASE_CLKS(2), .IDLE_ADDR(16'hFFFF)) dut0 (
    .CLK_IN (clk), .RESET_IN (rst_n), .bus (bif0.master));
  mcu_bus_driver #(.PHASE_CLKS(1), .IDLE_ADDR(16'hFFFF)) dut1 (
    .CLK_IN (clk), .RESET_IN (rst_n), .bus (bif1.master));

  assign bif0.REQ_IN = req[0];       assign bif1.REQ_IN = req[1];
  assign bif0.REQ_RW_IN = req_rw[0]; assign bif1.REQ_RW_IN = req_rw[1];
  assign bif0.REQ_ADDR_IN = req_addr[0];   assign bif1.REQ_ADDR_IN = req_addr[1];
  assign bif0.REQ_WDATA_IN = req_wdata[0]; assign bif1.REQ_WDATA_IN = req_wdata[1];
  assign bif0.P3_IN = p3_in[0];      assign bif1.P3_IN = p3_in[1];

  assign obs[0] = {bif0.E_OUT, bif0.AS_OUT, bif0.RW_OUT, bif0.P4_OUT, bif0.P3_OUT,
                   bif0.P3_IOM, bif0.READY_OUT, bif0.DONE_OUT, bif0.RDATA_OUT};
  assign obs[1] = {bif1.E_OUT, bif1.AS_OUT, bif1.RW_OUT, bif1.P4_OUT, bif1.P3_OUT,
                   bif1.P3_IOM, bif1.READY_OUT, bif1.DONE_OUT, bif1.RDATA_OUT};

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, i, $time, act, exp);
    end
  endtask

  // Timeline model: edges counts rising edges since reset release; edge 1 is
  // START, then each bus cycle spans 4*N edges. cur is the cycle's transaction.
  int          edges   [2] = '{0, 0};
  mtxn_t       cur     [2] = '{'0, '0};
  logic        done_e  [2] = '{1'b0, 1'b0};
  logic [7:0]  rdata_e [2] = '{8'h00, 8'h00};
  logic        acc     [2] = '{1'b0, 1'b0};

  function automatic int nclk(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        edges[i] <= 0; cur[i] <= '0; done_e[i] <= 1'b0;
        rdata_e[i] <= 8'h00; acc[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int    p;
        bit    lastd, rdy, dn, a;
        mtxn_t nxt;
        logic [7:0] rd;
        p     = 4 * nclk(i);
        lastd = (edges[i] >= 2) && (((edges[i] - 2) % p) == p - 1);
        rdy   = (edges[i] == 1) || lastd;
        nxt   = cur[i];
        dn    = 1'b0;
        rd    = rdata_e[i];
        if (lastd) begin
          if (cur[i].valid) begin
            dn = 1'b1;
            if (cur[i].rw) rd = p3_in[i];
          end
          nxt.valid = 1'b0;
        end
        a = rdy && req[i];
        if (a) nxt = '{valid: 1'b1, rw: req_rw[i], addr: req_addr[i], wdata: req_wdata[i]};
        cur[i]     <= nxt;
        done_e[i]  <= dn;
        rdata_e[i] <= rd;
        acc[i]     <= a;
        edges[i]   <= edges[i] + 1;
      end
    end
  end

  // -2 = reset/pre-START, -1 = START, 0..3 = phases A..D
  function automatic int model_phase(input int i);
    if (edges[i] == 0) return -2;
    if (edges[i] == 1) return -1;
    return ((edges[i] - 2) % (4 * nclk(i))) / nclk(i);
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t x; int n, pos, ph; logic [15:0] a; logic rw;
    n = nclk(i);
    x = '0; x.rw = 1'b1; x.done = done_e[i]; x.rdata = rdata_e[i];
    if (edges[i] == 1) x.ready = 1'b1;
    else if (edges[i] >= 2) begin
      pos = (edges[i] - 2) % (4 * n);
      ph  = pos / n;
      a   = cur[i].valid ? cur[i].addr : 16'hFFFF;
      rw  = cur[i].valid ? cur[i].rw : 1'b1;
      x.e = (ph >= 2); x.ast = (ph == 0); x.rw = rw;
      x.p4 = a[15:8]; x.p3 = a[7:0];
      x.iom = (ph < 2) || (cur[i].valid && !rw);
      if (ph >= 2 && x.iom) x.p3 = cur[i].wdata;
      x.ready = (pos == 4 * n - 1);
    end
    return x;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      obs_t x; int ph;
      x  = model_obs(i);
      ph = model_phase(i);
      chk("e", i, 32'(obs[i].e), 32'(x.e));
      chk("as", i, 32'(obs[i].ast), 32'(x.ast));
      chk("ready", i, 32'(obs[i].ready), 32'(x.ready));
      chk("done", i, 32'(obs[i].done), 32'(x.done));
      chk("rdata", i, 32'(obs[i].rdata), 32'(x.rdata));
      if (ph != -1) chk("rw", i, 32'(obs[i].rw), 32'(x.rw));
      if (ph != -1) chk("iom", i, 32'(obs[i].iom), 32'(x.iom));
      if (ph == -2 || ph == 0 || ph == 1) begin
        chk("p4", i, 32'(obs[i].p4), 32'(x.p4));
        chk("p3_addr", i, 32'(obs[i].p3), 32'(x.p3));
      end
      if (ph >= 2 && x.iom) chk("p3_wdata", i, 32'(obs[i].p3), 32'(x.p3));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input int i, input logic rw, input logic [15:0] a, input logic [7:0] d);
    int n;
    #1;
    req[i] = 1'b1; req_rw[i] = rw; req_addr[i] = a; req_wdata[i] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!acc[i] && n < 64);
    chk("accept_seen", i, 32'(acc[i]), 32'd1);
  endtask

  task automatic e_period(input int i, input int exp);
    int n; logic prev; bit found;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0; found = 1'b0; prev = obs[i].e;
      while (!found && n < 40) begin
        @(negedge clk); n++;
        found = obs[i].e && !prev;
        prev  = obs[i].e;
      end
    end
    chk("e_period", i, 32'(n), 32'(exp));
  endtask

  task automatic count_high(input string name, input int i, input int win,
                            input int sel, input int exp);
    int c;
    c = 0;
    repeat (win) begin
      @(negedge clk);
      if (sel == 0 && obs[i].ast)  c++;
      if (sel == 1 && obs[i].done) c++;
    end
    chk(name, i, 32'(c), 32'(exp));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; req_rw[i] = 1'b1; req_addr[i] = 16'h0000;
      req_wdata[i] = 8'h00; p3_in[i] = 8'h00;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk("reset_values", i, 32'(obs[i]), 32'(RST_OBS));
    step(3);
    #1 rst_n = 1'b1;

    // Idle dummy cycles
    @(negedge clk);
    chk("start_ready", 0, 32'(obs[0].ready), 32'd1);
    @(negedge clk);
    chk("dummy_p4", 0, 32'(obs[0].p4), 32'hFF);
    chk("dummy_p3", 0, 32'(obs[0].p3), 32'hFF);
    e_period(0, 8);
    e_period(1, 4);
    count_high("as_clocks", 0, 16, 0, 4);
    count_high("no_done", 0, 16, 1, 0);

    // Write 0x1005 <- 0x5A
    issue(0, 1'b0, 16'h1005, 8'h5A);
    chk("wr_p4", 0, 32'(obs[0].p4), 32'h10);
    chk("wr_p3", 0, 32'(obs[0].p3), 32'h05);
    chk("wr_rw", 0, 32'(obs[0].rw), 32'd0);
    chk("wr_as", 0, 32'(obs[0].ast), 32'd1);
    #1 req[0] = 1'b0;
    step(4);
    chk("wr_data", 0, 32'(obs[0].p3), 32'h5A);
    chk("wr_iom", 0, 32'(obs[0].iom), 32'd1);
    chk("wr_e", 0, 32'(obs[0].e), 32'd1);
    step(3);
    chk("wr_done_early", 0, 32'(obs[0].done), 32'd0);
    step(1);
    chk("wr_done", 0, 32'(obs[0].done), 32'd1);

    // Read 0xC000 returning 0x3C
    p3_in[0] = 8'h3C;
    issue(0, 1'b1, 16'hC000, 8'h00);
    chk("rd_rw", 0, 32'(obs[0].rw), 32'd1);
    chk("rd_p4", 0, 32'(obs[0].p4), 32'hC0);
    #1 req[0] = 1'b0;
    step(4);
    chk("rd_iom", 0, 32'(obs[0].iom), 32'd0);
    step(3);
    chk("rd_rdata_early", 0, 32'(obs[0].rdata), 32'h00);
    step(1);
    chk("rd_done", 0, 32'(obs[0].done), 32'd1);
    chk("rd_rdata", 0, 32'(obs[0].rdata), 32'h3C);

    // Back-to-back write 0x2000 then read 0xC000
    issue(0, 1'b0, 16'h2000, 8'h11);
    #1 req_rw[0] = 1'b1; req_addr[0] = 16'hC000;
    n = 0;
    do begin @(negedge clk); n++; end while (!acc[0] && n < 64);
    chk("b2b_gap", 0, 32'(n), 32'd8);
    chk("b2b_done1", 0, 32'(obs[0].done), 32'd1);
    #1 req[0] = 1'b0;
    step(8);
    chk("b2b_done2", 0, 32'(obs[0].done), 32'd1);

    // Reset during phase C of a write
    issue(0, 1'b0, 16'h3456, 8'hA5);
    #1 req[0] = 1'b0;
    step(4);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk("midreset_values", i, 32'(obs[i]), 32'(RST_OBS));
    step(2);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("restart_ready", 0, 32'(obs[0].ready), 32'd1);
    @(negedge clk);
    chk("restart_dummy_as", 0, 32'(obs[0].ast), 32'd1);
    chk("restart_dummy_p4", 0, 32'(obs[0].p4), 32'hFF);
    count_high("aborted_no_done", 0, 16, 1, 0);

    // PHASE_CLKS=1 read 0x1005
    p3_in[1] = 8'h77;
    issue(1, 1'b1, 16'h1005, 8'h00);
    #1 req[1] = 1'b0;
    step(3);
    chk("n1_done_early", 1, 32'(obs[1].done), 32'd0);
    step(1);
    chk("n1_done", 1, 32'(obs[1].done), 32'd1);
    chk("n1_rdata", 1, 32'(obs[1].rdata), 32'h77);

    // Randomized traffic on both instances
    repeat (3000) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || acc[i]) begin
          req[i]       = ($urandom % 4) != 0;
          req_rw[i]    = 1'($urandom % 2);
          req_addr[i]  = 16'($urandom);
          req_wdata[i] = 8'($urandom);
        end
        p3_in[i] = 8'($urandom);
      end
    end
    #1 req[0] = 1'b0; req[1] = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mcu_bus_driver.md
# mcu_bus_driver

Synthesizable HD6301-style multiplexed-bus master that turns single-word read/write requests into E/AS/RW bus cycles on ports P3 (address low/data) and P4 (address high). It sits directly upstream of IC19 and drives its E_IN, AS_IN, RW_IN, CPU_P3_IN and CPU_P4_IN from a simple request interface. This replaces hand-written bus stimulus in benches and serves as the CPU bus front end in the FPGA build. It runs free-running dummy cycles when idle, as the real CPU does.

## Interface
Parameters:
- PHASE_CLKS, 2, clocks per bus phase (≥1); one bus cycle = 4·PHASE_CLKS clocks
- IDLE_ADDR, 16'hFFFF, address driven on dummy cycles

Ports:
- CLK_IN  in  1  single clock; everything is on its rising edge
- RESET_IN  in  1  asynchronous, active-low reset
- REQ_IN  in  1  request valid; hold until accepted
- REQ_RW_IN  in  1  1 = read, 0 = write
- REQ_ADDR_IN  in  16  transaction address
- REQ_WDATA_IN  in  8  write data
- READY_OUT  out  1  accept slot; a request is accepted on an edge where REQ_IN & READY_OUT
- DONE_OUT  out  1  one-clock pulse when an accepted transaction finishes
- RDATA_OUT  out  8  read data; valid from the DONE pulse until the next read's DONE
- E_OUT, AS_OUT, RW_OUT  out  1 each  bus strobes
- P4_OUT  out  8  address high
- P3_OUT  out  8  address low / write data
- P3_IOM  out  1  1 = P3 driven by this block, 0 = P3 is input
- P3_IN  in  8  read data from the bus

## Operation
- Bus cycle phases, each PHASE_CLKS clocks:
  - A: E=0, AS=1, P4/P3 = address, IOM=1
  - B: E=0, AS=0, address held
  - C: E=1, AS=0. On a write, P3 = wdata and IOM=1. On a read, IOM=0.
  - D: same as C.
- The next cycle always follows D immediately, so E runs continuously.
- States: START (one clock after reset release), then A→B→C→D→A…
- READY_OUT=1 during START and during the last clock of D only.
- Acceptance latches addr/rw/wdata; the next cycle carries that transaction.
- No acceptance means the next cycle is a dummy: addr=IDLE_ADDR, RW=1, IOM=0 in C/D, no DONE.
- RW_OUT is held for the whole cycle: 0 for writes, 1 otherwise.
- Read: P3_IN is sampled at the edge ending D into RDATA_OUT. Writes leave RDATA_OUT unchanged.
- DONE_OUT is registered and high for the one clock following the edge that ends the transaction's D.
- Back-to-back: a REQ_IN presented during the final D clock is accepted, leaving no dummy cycle between transactions.

## Timing
- Reset values, applied asynchronously while RESET_IN=0:
  - E=0, AS=0, RW=1, P3_OUT=0, P4_OUT=0, IOM=0
  - READY=0, DONE=0, RDATA=0
  - internal state START, latched request cleared
- After RESET_IN rises: START occupies one clock with READY=1, then phase A begins.
- Accept at edge t0: phase A covers t0..t0+N−1 (N = PHASE_CLKS); P3 is sampled at edge t0+4N; DONE is high between t0+4N and t0+4N+1.
- Reset mid-cycle aborts the transaction: no DONE, and the request is not retried.
- The phase counter is ceil(log2(PHASE_CLKS)) bits wide, minimum 1, and wraps to 0 on each phase change.

## Structure
- Package rdpiano_bus_pkg holds:
  - the phase enum (START, A, B, C, D)
  - the bus_req struct {rw, addr[15:0], wdata[7:0]}
  - the default IDLE_ADDR constant
- Sub-module mcu_phase_timer: counts PHASE_CLKS and emits phase_last and cycle_last strobes. The top level holds the phase FSM, request latch and output registers.

## Test plan
- Reset, PHASE_CLKS=2, no REQ → reset values as listed; after release, dummy cycles with P4/P3=FF/FF, AS high for 2 clocks, E period 8 clocks, DONE never asserts.
- Write 0x1005 ← 0x5A → phase A P4=10 P3=05 RW=0; C/D P3=5A IOM=1; DONE exactly 8 clocks after the accept edge.
- Read 0xC000, P3_IN=0x3C during D → IOM=0 in C/D, RDATA_OUT=3C coincident with DONE, RW=1 throughout.
- REQ held for write 0x2000 then read 0xC000 → no dummy cycle between them, E period constant at 8, two DONE pulses 8 clocks apart.
- RESET_IN low during phase C of a write → all outputs at reset values immediately, no DONE; after release START then a dummy cycle.
- PHASE_CLKS=1 read 0x1005 → bus cycle is 4 clocks, DONE 4 clocks after the accept edge.
